// File: rtl/snitch_axi_rom_responder_if.sv
// AXI4 channel bundle between a read-only memory responder and the master driving it.
// Only the fields the responder consumes or produces are carried.
interface snitch_axi_rom_responder_if #(
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 2,
    parameter int unsigned AxiUserWidth = 1
);
    logic                    aw_valid;
    logic                    aw_ready;
    logic [AxiIdWidth-1:0]   aw_id;

    logic                    w_valid;
    logic                    w_ready;
    logic                    w_last;

    logic                    b_valid;
    logic                    b_ready;
    logic [AxiIdWidth-1:0]   b_id;
    logic [1:0]              b_resp;
    logic [AxiUserWidth-1:0] b_user;

    logic                    ar_valid;
    logic                    ar_ready;
    logic [AxiIdWidth-1:0]   ar_id;
    logic [AxiAddrWidth-1:0] ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;

    logic                    r_valid;
    logic                    r_ready;
    logic [AxiIdWidth-1:0]   r_id;
    logic [AxiDataWidth-1:0] r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [AxiUserWidth-1:0] r_user;

    modport master (
        output aw_valid, aw_id, w_valid, w_last, b_ready,
               ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        input  aw_ready, w_ready, b_valid, b_id, b_resp, b_user,
               ar_ready, r_valid, r_id, r_data, r_resp, r_last, r_user
    );

    modport slave (
        input  aw_valid, aw_id, w_valid, w_last, b_ready,
               ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        output aw_ready, w_ready, b_valid, b_id, b_resp, b_user,
               ar_ready, r_valid, r_id, r_data, r_resp, r_last, r_user
    );
endinterface

// File: rtl/snitch_axi_rom_responder.sv
// AXI4 read-only responder: serves in-order R bursts from a 1-cycle synchronous SRAM
// through a tagged pipeline stage and a 2-entry fall-through FIFO; writes get SLVERR.
module snitch_axi_rom_responder #(
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 2,
    parameter int unsigned AxiUserWidth = 1,
    parameter int unsigned MemWords     = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    snitch_axi_rom_responder_if.slave   axi,
    output logic                        mem_req_o,
    output logic [$clog2(MemWords)-1:0] mem_addr_o,
    input  logic [AxiDataWidth-1:0]     mem_rdata_i
);
    localparam int unsigned StrbW = AxiDataWidth / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned IdxW  = $clog2(MemWords);
    localparam logic [AxiAddrWidth-1:0] MemLimit = AxiAddrWidth'(MemWords);
    localparam logic [AxiAddrWidth-1:0] AddrStep = AxiAddrWidth'(StrbW);
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic       {R_IDLE, R_BURST}         r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_e;

    r_state_e                r_state_q, r_state_d;
    w_state_e                w_state_q, w_state_d;
    logic                    rdy_q;

    logic [AxiIdWidth-1:0]   ar_id_q, ar_id_d;
    logic [AxiAddrWidth-1:0] addr_q, addr_d;
    logic [7:0]              len_cnt_q, len_cnt_d;
    logic [1:0]              burst_q, burst_d;
    logic [2:0]              size_q, size_d;
    logic [AxiIdWidth-1:0]   aw_id_q, aw_id_d;

    logic                    vld_p1_q, vld_p1_d;
    logic [AxiIdWidth-1:0]   id_p1_q, id_p1_d;
    logic [1:0]              resp_p1_q, resp_p1_d;
    logic                    last_p1_q, last_p1_d;

    logic [AxiIdWidth-1:0]   fifo_id_q   [2];
    logic [AxiIdWidth-1:0]   fifo_id_d   [2];
    logic [AxiDataWidth-1:0] fifo_data_q [2];
    logic [AxiDataWidth-1:0] fifo_data_d [2];
    logic [1:0]              fifo_resp_q [2];
    logic [1:0]              fifo_resp_d [2];
    logic                    fifo_last_q [2];
    logic                    fifo_last_d [2];
    logic                    head_q, head_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;

    logic                    issue;
    logic [1:0]              beat_resp;
    logic [AxiAddrWidth-1:0] word_idx;
    logic [AxiDataWidth-1:0] data_p1;
    logic                    push, pop, wr_ptr;

    // Control state: cleared asynchronously so every handshake output drops at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_q  <= R_IDLE;
            w_state_q  <= W_IDLE;
            rdy_q      <= 1'b0;
            vld_p1_q   <= 1'b0;
            head_q     <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            r_state_q  <= r_state_d;
            w_state_q  <= w_state_d;
            rdy_q      <= 1'b1;
            vld_p1_q   <= vld_p1_d;
            head_q     <= head_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Payload registers are qualified by the control state above and need no reset.
    always_ff @(posedge clk_i) begin
        ar_id_q     <= ar_id_d;
        addr_q      <= addr_d;
        len_cnt_q   <= len_cnt_d;
        burst_q     <= burst_d;
        size_q      <= size_d;
        aw_id_q     <= aw_id_d;
        id_p1_q     <= id_p1_d;
        resp_p1_q   <= resp_p1_d;
        last_p1_q   <= last_p1_d;
        fifo_id_q   <= fifo_id_d;
        fifo_data_q <= fifo_data_d;
        fifo_resp_q <= fifo_resp_d;
        fifo_last_q <= fifo_last_d;
    end

    // Issue stage: credit check, response classification, SRAM strobe.
    always_comb begin
        word_idx  = addr_q >> OffW;
        issue     = (r_state_q == R_BURST) && ((fifo_cnt_q + {1'b0, vld_p1_q}) < 2'd2);
        beat_resp = RespOkay;
        if ((burst_q == BurstWrap) || (size_q != 3'(OffW))) begin
            beat_resp = RespSlvErr;
        end else if (word_idx >= MemLimit) begin
            beat_resp = RespDecErr;
        end
        mem_req_o    = issue && (beat_resp == RespOkay);
        mem_addr_o   = mem_req_o ? word_idx[IdxW-1:0] : '0;
        axi.ar_ready = (r_state_q == R_IDLE) && rdy_q;
    end

    always_comb begin
        r_state_d = r_state_q;
        ar_id_d   = ar_id_q;
        addr_d    = addr_q;
        len_cnt_d = len_cnt_q;
        burst_d   = burst_q;
        size_d    = size_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (axi.ar_valid && axi.ar_ready) begin
                    ar_id_d   = axi.ar_id;
                    addr_d    = axi.ar_addr;
                    len_cnt_d = axi.ar_len;
                    burst_d   = axi.ar_burst;
                    size_d    = axi.ar_size;
                    r_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (issue) begin
                    if (len_cnt_q == 8'd0) begin
                        r_state_d = R_IDLE;
                    end else begin
                        len_cnt_d = len_cnt_q - 8'd1;
                    end
                    if (burst_q != BurstFixed) begin
                        addr_d = addr_q + AddrStep;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Stage p1: beat tag travels alongside the SRAM read it waits on.
    always_comb begin
        vld_p1_d  = issue;
        id_p1_d   = ar_id_q;
        resp_p1_d = beat_resp;
        last_p1_d = (len_cnt_q == 8'd0);
    end

    // R FIFO: the p1 beat bypasses straight to R when the FIFO is empty.
    always_comb begin
        data_p1     = (resp_p1_q == RespOkay) ? mem_rdata_i : '0;
        push        = vld_p1_q && !((fifo_cnt_q == 2'd0) && axi.r_ready);
        pop         = (fifo_cnt_q != 2'd0) && axi.r_ready;
        wr_ptr      = head_q ^ fifo_cnt_q[0];
        fifo_id_d   = fifo_id_q;
        fifo_data_d = fifo_data_q;
        fifo_resp_d = fifo_resp_q;
        fifo_last_d = fifo_last_q;
        if (push) begin
            fifo_id_d[wr_ptr]   = id_p1_q;
            fifo_data_d[wr_ptr] = data_p1;
            fifo_resp_d[wr_ptr] = resp_p1_q;
            fifo_last_d[wr_ptr] = last_p1_q;
        end
        head_d     = head_q ^ pop;
        fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);

        if (fifo_cnt_q != 2'd0) begin
            axi.r_id   = fifo_id_q[head_q];
            axi.r_data = fifo_data_q[head_q];
            axi.r_resp = fifo_resp_q[head_q];
            axi.r_last = fifo_last_q[head_q];
        end else begin
            axi.r_id   = id_p1_q;
            axi.r_data = data_p1;
            axi.r_resp = resp_p1_q;
            axi.r_last = last_p1_q;
        end
        axi.r_valid = (fifo_cnt_q != 2'd0) || vld_p1_q;
        axi.r_user  = '0;
    end

    // Write path: drain the burst, then answer with a single SLVERR.
    always_comb begin
        w_state_d = w_state_q;
        aw_id_d   = aw_id_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (axi.aw_valid && rdy_q) begin
                    aw_id_d   = axi.aw_id;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: if (axi.w_valid && axi.w_last) w_state_d = W_RESP;
            W_RESP: if (axi.b_ready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        axi.aw_ready = (w_state_q == W_IDLE) && rdy_q;
        axi.w_ready  = (w_state_q == W_DATA);
        axi.b_valid  = (w_state_q == W_RESP);
        axi.b_id     = aw_id_q;
        axi.b_resp   = RespSlvErr;
        axi.b_user   = '0;
    end
endmodule

// File: tb/tb_snitch_axi_rom_responder.sv
// Directed bench for snitch_axi_rom_responder: reads, refills, backpressure,
// error classes, write rejection and reset mid-burst.
module tb_snitch_axi_rom_responder;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 2;
    localparam int unsigned UW = 1;
    localparam int unsigned MW = 1024;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    snitch_axi_rom_responder_if #(.AxiAddrWidth(AW), .AxiDataWidth(DW),
                                  .AxiIdWidth(IW), .AxiUserWidth(UW)) axi ();

    logic        mem_req;
    logic [9:0]  mem_addr;
    logic [63:0] mem_rdata = '0;

    snitch_axi_rom_responder #(
        .AxiAddrWidth(AW), .AxiDataWidth(DW), .AxiIdWidth(IW),
        .AxiUserWidth(UW), .MemWords(MW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .axi         (axi.slave),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata)
    );

    function automatic logic [63:0] mem_word(input logic [9:0] i);
        return (i == 10'd5) ? 64'hA5 : (64'h1111_0000_0000_0000 | {54'h0, i});
    endfunction

    // SRAM model: 1-cycle latency, garbage when not strobed.
    always @(posedge clk) mem_rdata <= mem_req ? mem_word(mem_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          memreq_cnt = 0;
    int          last_req_cyc = -1;
    logic [9:0]  last_req_addr = '0;
    always @(negedge clk) begin
        if (mem_req) begin
            memreq_cnt    <= memreq_cnt + 1;
            last_req_cyc  <= cyc;
            last_req_addr <= mem_addr;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] b_data [300];
    logic [1:0]  b_resp [300];
    logic [1:0]  b_id   [300];
    logic        b_last [300];
    logic        b_arr  [300];
    int          b_cyc  [300];
    int          nbeats;
    int          stab_err;
    int          ar_t;
    int          aw_t;

    task automatic send_ar(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int k;
        @(negedge clk);
        axi.ar_id = id; axi.ar_addr = addr; axi.ar_len = len;
        axi.ar_size = size; axi.ar_burst = burst; axi.ar_valid = 1'b1;
        k = 0;
        while (!axi.ar_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        ar_t = axi.ar_ready ? cyc : -1000;
        @(negedge clk);
        axi.ar_valid = 1'b0;
    endtask

    // Records accepted R beats under an r_ready pattern, then idles 4 cycles to catch extras.
    task automatic collect(input int n, input logic [5:0] pat, input int budget);
        logic        rdy, stall, sl;
        logic [63:0] sd;
        logic [1:0]  sr, si;
        int          idle;
        nbeats = 0; stab_err = 0; stall = 1'b0; idle = 0;
        sd = '0; sr = '0; si = '0; sl = 1'b0;
        for (int k = 0; k < budget && idle < 4; k++) begin
            @(negedge clk);
            rdy = (nbeats >= n) ? 1'b1 : pat[k % 6];
            axi.r_ready = rdy;
            if (stall && (!axi.r_valid || axi.r_data !== sd || axi.r_resp !== sr ||
                          axi.r_id !== si || axi.r_last !== sl)) stab_err++;
            stall = axi.r_valid && !rdy;
            sd = axi.r_data; sr = axi.r_resp; si = axi.r_id; sl = axi.r_last;
            if (axi.r_valid && rdy && nbeats < 300) begin
                b_data[nbeats] = axi.r_data; b_resp[nbeats] = axi.r_resp;
                b_id[nbeats]   = axi.r_id;   b_last[nbeats] = axi.r_last;
                b_cyc[nbeats]  = cyc;        b_arr[nbeats]  = axi.ar_ready;
                nbeats++;
            end
            if (nbeats >= n) idle++;
        end
        axi.r_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (axi.ar_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ar_ready got %b want 0", axi.ar_ready); end
        n_tests++;
        if (axi.aw_ready !== 1'b0) begin n_fail++; $display("FAIL reset_aw_ready got %b want 0", axi.aw_ready); end
        n_tests++;
        if ({axi.w_ready, axi.r_valid, axi.b_valid} !== 3'b000)
            begin n_fail++; $display("FAIL reset_valids got %b want 000", {axi.w_ready, axi.r_valid, axi.b_valid}); end
        n_tests++;
        if ({mem_req, mem_addr} !== 11'd0) begin n_fail++; $display("FAIL reset_mem got %h want 0", {mem_req, mem_addr}); end
        rst_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({axi.ar_ready, axi.aw_ready} !== 2'b11)
            begin n_fail++; $display("FAIL post_reset_ready got %b want 11", {axi.ar_ready, axi.aw_ready}); end
    endtask

    task automatic test_single_read();
        int base;
        base = memreq_cnt;
        send_ar(2'd2, 32'h28, 8'd0, 3'd3, 2'b01);
        collect(1, 6'h3F, 20);
        n_tests++;
        if (nbeats !== 1) begin n_fail++; $display("FAIL single_count got %0d want 1", nbeats); end
        n_tests++;
        if ({b_data[0], b_resp[0], b_id[0], b_last[0]} !== {64'hA5, 2'b00, 2'd2, 1'b1})
            begin n_fail++; $display("FAIL single_beat got data=%h resp=%0d id=%0d last=%b want a5/0/2/1", b_data[0], b_resp[0], b_id[0], b_last[0]); end
        n_tests++;
        if (b_cyc[0] !== ar_t + 2) begin n_fail++; $display("FAIL single_latency got %0d want %0d", b_cyc[0], ar_t + 2); end
        n_tests++;
        if ({memreq_cnt - base, last_req_cyc, 22'(last_req_addr)} !== {1, ar_t + 1, 22'd5})
            begin n_fail++; $display("FAIL single_memreq got n=%0d cyc=%0d addr=%0d want 1/%0d/5", memreq_cnt - base, last_req_cyc, last_req_addr, ar_t + 1); end
        n_tests++;
        if (axi.r_user !== 1'b0) begin n_fail++; $display("FAIL r_user got %b want 0", axi.r_user); end
    endtask

    task automatic test_incr_refill();
        logic [63:0] exp [4];
        int bad;
        exp[0] = 64'h1111_0000_0000_0008; exp[1] = 64'h1111_0000_0000_0009;
        exp[2] = 64'h1111_0000_0000_000A; exp[3] = 64'h1111_0000_0000_000B;
        send_ar(2'd1, 32'h40, 8'd3, 3'd3, 2'b01);
        collect(4, 6'h3F, 30);
        n_tests++;
        if (nbeats !== 4) begin n_fail++; $display("FAIL refill_count got %0d want 4", nbeats); end
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (b_data[i] !== exp[i] || b_resp[i] !== 2'b00 || b_last[i] !== (i == 3) || b_cyc[i] !== ar_t + 2 + i) bad++;
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL refill_beats got %0d bad beats want 0", bad); end
        n_tests++;
        if ({b_arr[2], b_arr[3]} !== 2'b01)
            begin n_fail++; $display("FAIL refill_ar_ready got %b want 01", {b_arr[2], b_arr[3]}); end
    endtask

    task automatic test_backpressure();
        int bad;
        send_ar(2'd0, 32'h40, 8'd3, 3'd3, 2'b01);
        collect(4, 6'b101001, 60);
        n_tests++;
        if (nbeats !== 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", nbeats); end
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (b_data[i] !== (64'h1111_0000_0000_0008 + 64'(i)) || b_last[i] !== (i == 3)) bad++;
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL bp_order got %0d bad beats want 0", bad); end
        n_tests++;
        if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", stab_err); end
    endtask

    task automatic test_errors();
        int base, bad;
        base = memreq_cnt;
        send_ar(2'd3, 32'h40, 8'd3, 3'd3, 2'b10);
        collect(4, 6'h3F, 30);
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (b_resp[i] !== 2'b10 || b_data[i] !== 64'h0 || b_last[i] !== (i == 3)) bad++;
        n_tests++;
        if (nbeats !== 4 || bad !== 0) begin n_fail++; $display("FAIL wrap_beats got n=%0d bad=%0d want 4/0", nbeats, bad); end
        n_tests++;
        if (memreq_cnt !== base) begin n_fail++; $display("FAIL wrap_memreq got %0d want 0", memreq_cnt - base); end

        send_ar(2'd1, 32'h1FF0, 8'd3, 3'd3, 2'b01);
        collect(4, 6'h3F, 30);
        n_tests++;
        if ({b_resp[0], b_resp[1], b_resp[2], b_resp[3]} !== 8'b00_00_11_11 || nbeats !== 4)
            begin n_fail++; $display("FAIL decerr_resp got %b%b%b%b n=%0d want 00001111/4", b_resp[0], b_resp[1], b_resp[2], b_resp[3], nbeats); end
        n_tests++;
        if ({b_data[0], b_data[1], b_data[2], b_data[3]} !==
            {64'h1111_0000_0000_03FE, 64'h1111_0000_0000_03FF, 64'h0, 64'h0})
            begin n_fail++; $display("FAIL decerr_data got %h %h %h %h", b_data[0], b_data[1], b_data[2], b_data[3]); end

        send_ar(2'd2, 32'h0, 8'd1, 3'd2, 2'b01);
        collect(2, 6'h3F, 20);
        n_tests++;
        if (nbeats !== 2 || {b_resp[0], b_resp[1], b_last[0], b_last[1]} !== 6'b10_10_0_1)
            begin n_fail++; $display("FAIL size_err got n=%0d resp=%0d,%0d last=%b%b want 2/2,2/01", nbeats, b_resp[0], b_resp[1], b_last[0], b_last[1]); end
    endtask

    task automatic test_long_burst();
        int bad;
        send_ar(2'd1, 32'h0, 8'd255, 3'd3, 2'b01);
        collect(256, 6'h3F, 300);
        n_tests++;
        if (nbeats !== 256) begin n_fail++; $display("FAIL long_count got %0d want 256", nbeats); end
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (b_data[i] !== mem_word(10'(i)) || b_last[i] !== (i == 255)) bad++;
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL long_beats got %0d bad beats want 0", bad); end
        n_tests++;
        if (b_cyc[255] !== ar_t + 257) begin n_fail++; $display("FAIL long_finish got %0d want %0d", b_cyc[255], ar_t + 257); end
    endtask

    task automatic test_write();
        logic early_wr, b_after;
        logic [4:0] bfields;
        int u, b_t, b_early, k, bad;
        b_early = 0; u = -1000; b_t = -2000; early_wr = 1'b0; b_after = 1'b1; bfields = '0;
        fork
            begin
                send_ar(2'd3, 32'h40, 8'd3, 3'd3, 2'b01);
                collect(4, 6'h3F, 30);
            end
            begin
                @(negedge clk);
                axi.aw_id = 2'd1; axi.aw_valid = 1'b1; axi.w_valid = 1'b1; axi.w_last = 1'b0;
                early_wr = axi.w_ready;
                k = 0;
                while (!axi.aw_ready && k < 20) begin @(negedge clk); k++; end
                aw_t = axi.aw_ready ? cyc : -3000;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    axi.aw_valid = 1'b0;
                    axi.w_last = (i == 2);
                    k = 0;
                    while (!axi.w_ready && k < 20) begin @(negedge clk); k++; end
                    if (axi.b_valid) b_early++;
                    u = cyc;
                end
                @(negedge clk);
                axi.w_valid = 1'b0; axi.w_last = 1'b0;
                k = 0;
                while (!axi.b_valid && k < 20) begin @(negedge clk); k++; end
                b_t = axi.b_valid ? cyc : -2000;
                bfields = {axi.b_id, axi.b_resp, axi.b_user};
                @(negedge clk);
                b_after = axi.b_valid;
            end
        join
        n_tests++;
        if (early_wr !== 1'b0) begin n_fail++; $display("FAIL w_before_aw got w_ready=%b want 0", early_wr); end
        n_tests++;
        if (aw_t !== ar_t) begin n_fail++; $display("FAIL ar_aw_same_cycle got aw=%0d ar=%0d", aw_t, ar_t); end
        n_tests++;
        if (b_t !== u + 1 || b_early !== 0) begin n_fail++; $display("FAIL b_timing got %0d early=%0d want %0d/0", b_t, b_early, u + 1); end
        n_tests++;
        if (bfields !== {2'd1, 2'b10, 1'b0} || b_after !== 1'b0)
            begin n_fail++; $display("FAIL b_fields got %b after=%b want 01100/0", bfields, b_after); end
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (b_data[i] !== (64'h1111_0000_0000_0008 + 64'(i)) || b_id[i] !== 2'd3) bad++;
        n_tests++;
        if (nbeats !== 4 || bad !== 0) begin n_fail++; $display("FAIL concurrent_read got n=%0d bad=%0d want 4/0", nbeats, bad); end
    endtask

    task automatic test_reset_mid_burst();
        logic [17:0] outs;
        send_ar(2'd0, 32'h0, 8'd7, 3'd3, 2'b01);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (axi.r_valid !== 1'b1) begin n_fail++; $display("FAIL mid_burst_active got r_valid=%b want 1", axi.r_valid); end
        rst_i = 1'b1;
        #1;
        outs = {axi.r_valid, axi.ar_ready, axi.aw_ready, axi.w_ready, axi.b_valid, mem_req, 2'b00, mem_addr};
        n_tests++;
        if (outs !== 18'd0) begin n_fail++; $display("FAIL async_reset_outputs got %h want 0", outs); end
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        send_ar(2'd2, 32'h28, 8'd0, 3'd3, 2'b01);
        collect(1, 6'h3F, 20);
        n_tests++;
        if (nbeats !== 1 || b_data[0] !== 64'hA5 || b_id[0] !== 2'd2 || b_cyc[0] !== ar_t + 2)
            begin n_fail++; $display("FAIL post_reset_read got n=%0d data=%h id=%0d cyc=%0d want 1/a5/2/%0d", nbeats, b_data[0], b_id[0], b_cyc[0], ar_t + 2); end
    endtask

    initial begin
        axi.aw_valid = 1'b0; axi.aw_id = '0; axi.w_valid = 1'b0; axi.w_last = 1'b0;
        axi.b_ready = 1'b1; axi.ar_valid = 1'b0; axi.ar_id = '0; axi.ar_addr = '0;
        axi.ar_len = '0; axi.ar_size = '0; axi.ar_burst = '0; axi.r_ready = 1'b1;
        test_reset();
        test_single_read();
        test_incr_refill();
        test_backpressure();
        test_errors();
        test_long_burst();
        test_write();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got cycle %0d want completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
